// File: rtl/ioblock_oser.sv
// ioblock_oser: output IO block with tristate, always-on and serializer drive modes, configured over a serial chain
module ioblock_oser #(
  parameter int WIDTH = 8
) (
  input  logic             IOCLK,
  input  logic             RST,
  inout  wire              PIN,
  input  logic             TS,
  input  logic             OUT,
  input  logic [WIDTH-1:0] DATA,
  input  logic             VALID,
  output logic             READY,
  output logic             BUSY,
  input  logic             CFGEN,
  input  logic             CFGIN,
  output logic             CFGOUT
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, nstate;
  logic [3:0] cfg;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0] cnt;
  logic oval, oen, fire, pin_en, pin_val;
  logic inv, oreg;
  logic [1:0] omode;
  assign inv = cfg[3];
  assign oreg = cfg[2];
  assign omode = cfg[1:0];
  assign READY = omode == 2'b11 && !CFGEN && (state == IDLE || cnt == '0);
  assign fire = VALID && READY;
  assign BUSY = state == SHIFT;
  assign CFGOUT = cfg[0];
  // Serializer next state; config activity or leaving serial mode forces IDLE
  always_comb begin
    nstate = state;
    if (CFGEN || omode != 2'b11) nstate = IDLE;
    else if (fire) nstate = SHIFT;
    else if (state == SHIFT && cnt == '0) nstate = IDLE;
  end
  // Config chain, FSM, shifter and registered-output flops
  always_ff @(posedge IOCLK) begin
    if (RST) begin
      cfg <= '0;
      state <= IDLE;
      shreg <= '0;
      cnt <= '0;
      oval <= 1'b0;
      oen <= 1'b0;
    end else begin
      if (CFGEN) cfg <= {CFGIN, cfg[3:1]};
      state <= nstate;
      oval <= OUT;
      oen <= TS;
      if (fire) begin
        shreg <= DATA;
        cnt <= CW'(WIDTH - 1);
      end else if (state == SHIFT) begin
        shreg <= shreg >> 1;
        cnt <= cnt - 1'b1;
      end
    end
  end
  // Pad enable and value selected by mode; inversion applies to every driven bit
  always_comb begin
    pin_en = omode == 2'b11 ? state == SHIFT : omode == 2'b10 ? 1'b1 : omode == 2'b01 ? (oreg ? oen : TS) : 1'b0;
    pin_val = (omode == 2'b11 ? shreg[0] : oreg ? oval : OUT) ^ inv;
  end
  assign PIN = pin_en ? pin_val : 1'bz;
endmodule
